// File: rtl/av_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : av_mem_arbiter                                             |
// | Description : Shares one single-read memory port between the video pixel |
// |               fetcher and the audio sample fetcher. Video has fixed      |
// |               priority; audio is forced through once it has waited       |
// |               AUD_MAX_WAIT cycles. One outstanding read at a time, with  |
// |               a timeout that completes the read with zero data and err.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   pclk, reset              pixel clock; synchronous active-low reset     |
// |   vid_req/vid_addr         video request (level) and address             |
// |   vid_ack/vid_rdata        video completion pulse and registered data    |
// |   aud_req/aud_addr         audio request (level) and address             |
// |   aud_ack/aud_rdata        audio completion pulse and registered data    |
// |   mem_rd/mem_addr          one-cycle read strobe, held address           |
// |   mem_rdata/mem_valid      memory reply                                  |
// |   err                      one-cycle pulse on read timeout               |
// |   stat_vid/aud/force       grant counters                                |
// | Build option                                                             |
// |   ARB_STATS_EN  defined  : saturating grant counters on stat_*           |
// |                 undefined: stat_* tied to zero, no counter logic         |
// +--------------------------------------------------------------------------+
module av_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int AUD_MAX_WAIT = 16,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              aud_req,
    input  logic [ADDR_W-1:0] aud_addr,
    output logic              aud_ack,
    output logic [DATA_W-1:0] aud_rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              err,
    output logic [15:0]       stat_vid,
    output logic [15:0]       stat_aud,
    output logic [15:0]       stat_force
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_VID  = 2'd1;
    localparam logic [1:0] S_AUD  = 2'd2;

    localparam logic [7:0] C_WAIT_MAX = 8'(AUD_MAX_WAIT);
    localparam logic [7:0] C_TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        r_tmo_cnt;
    logic              r_vid_ack;
    logic              r_aud_ack;
    logic              r_err;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_vid_rdata;
    logic [DATA_W-1:0] r_aud_rdata;

    logic              w_grant_vid;
    logic              w_grant_aud;
    logic              w_done;
    logic              w_timeout;

    // Next-state and grant decisions. On the ack cycle the requester still
    // holds its request, so IDLE does not arbitrate while an ack is out;
    // re-arbitration happens on the following cycle.
    always_comb begin
        w_state_next = r_state;
        w_grant_vid  = 1'b0;
        w_grant_aud  = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_vid_ack && !r_aud_ack) begin
                    if (aud_req && (r_wait_cnt >= C_WAIT_MAX)) begin
                        w_grant_aud  = 1'b1;
                        w_state_next = S_AUD;
                    end else if (vid_req) begin
                        w_grant_vid  = 1'b1;
                        w_state_next = S_VID;
                    end else if (aud_req) begin
                        w_grant_aud  = 1'b1;
                        w_state_next = S_AUD;
                    end
                end
            end
            S_VID, S_AUD: begin
                // Data arriving on the timeout cycle takes precedence.
                if (mem_valid) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_tmo_cnt == C_TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_tmo_cnt   <= 8'd0;
            r_vid_ack   <= 1'b0;
            r_aud_ack   <= 1'b0;
            r_err       <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_vid_rdata <= '0;
            r_aud_rdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mem_rd  <= w_grant_vid | w_grant_aud;
            r_vid_ack <= 1'b0;
            r_aud_ack <= 1'b0;
            r_err     <= w_timeout;

            if (w_grant_vid) begin
                r_mem_addr <= vid_addr;
            end else if (w_grant_aud) begin
                r_mem_addr <= aud_addr;
            end

            if (w_grant_vid || w_grant_aud) begin
                r_tmo_cnt <= 8'd0;
            end else if (r_state != S_IDLE) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end

            if (w_done || w_timeout) begin
                if (r_state == S_VID) begin
                    r_vid_ack   <= 1'b1;
                    r_vid_rdata <= w_done ? mem_rdata : '0;
                end else begin
                    r_aud_ack   <= 1'b1;
                    r_aud_rdata <= w_done ? mem_rdata : '0;
                end
            end

            // Audio starvation counter: counts every cycle audio is asking
            // but not being granted, saturating at the force threshold.
            if (!aud_req || w_grant_aud) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt < C_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign vid_ack   = r_vid_ack;
    assign aud_ack   = r_aud_ack;
    assign vid_rdata = r_vid_rdata;
    assign aud_rdata = r_aud_rdata;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;
    assign err       = r_err;

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_vid;
    logic [15:0] r_stat_aud;
    logic [15:0] r_stat_force;
    logic        w_force;

    // A forced grant is an audio grant taken at or above the wait threshold;
    // it is counted in both the audio and forced counters.
    assign w_force = w_grant_aud && (r_wait_cnt >= C_WAIT_MAX);

    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_stat_vid   <= 16'd0;
            r_stat_aud   <= 16'd0;
            r_stat_force <= 16'd0;
        end else begin
            if (w_grant_vid && (r_stat_vid != 16'hFFFF)) begin
                r_stat_vid <= r_stat_vid + 16'd1;
            end
            if (w_grant_aud && (r_stat_aud != 16'hFFFF)) begin
                r_stat_aud <= r_stat_aud + 16'd1;
            end
            if (w_force && (r_stat_force != 16'hFFFF)) begin
                r_stat_force <= r_stat_force + 16'd1;
            end
        end
    end

    assign stat_vid   = r_stat_vid;
    assign stat_aud   = r_stat_aud;
    assign stat_force = r_stat_force;
`else
    assign stat_vid   = 16'd0;
    assign stat_aud   = 16'd0;
    assign stat_force = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_av_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_av_mem_arbiter                                          |
// | Description : Self-checking bench for av_mem_arbiter: a per-cycle vector |
// |               table, hand sequences for forced grant and timeout, and a  |
// |               randomized run against a transaction-level reference.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_av_mem_arbiter;

    localparam int MAXW = 16;
    localparam int TMO  = 64;
    localparam int NRND = 4000;

    logic        pclk = 1'b0;
    logic        reset;
    logic        vid_req, aud_req, mem_valid;
    logic [15:0] vid_addr, aud_addr, mem_rdata;
    logic        vid_ack, aud_ack, mem_rd, err;
    logic [15:0] vid_rdata, aud_rdata, mem_addr;
    logic [15:0] stat_vid, stat_aud, stat_force;

    av_mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .AUD_MAX_WAIT(MAXW), .MEM_TIMEOUT(TMO)
    ) dut (
        .pclk(pclk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .aud_req(aud_req), .aud_addr(aud_addr), .aud_ack(aud_ack), .aud_rdata(aud_rdata),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .err(err), .stat_vid(stat_vid), .stat_aud(stat_aud), .stat_force(stat_force)
    );

    always #5 pclk = ~pclk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory contents as seen by the bench: a fixed scramble of the address.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        logic [31:0] p;
        p = {16'd0, a} * 32'h0000_9E37;
        return p[15:0] ^ 16'h1234;
    endfunction

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        vid_req = 1'b0; aud_req = 1'b0; mem_valid = 1'b0;
        vid_addr = '0; aud_addr = '0; mem_rdata = '0;
        repeat (3) next_cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        vr;
        logic [15:0] va;
        logic        ar;
        logic [15:0] aa;
        logic        mv;
        logic [15:0] md;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_vack;
        logic [15:0] e_vdat;
        logic        e_aack;
        logic [15:0] e_adat;
        logic        e_err;
    } vec_t;

    vec_t vt[24];

    // Shared state for the hand sequences and the random run.
    int          first_aud, nvid, rd_c, ack_c, err_c, seen_err;
    logic        rd_prev, aack_prev, got_err;
    logic [15:0] got_dat;
    int          cyc, out_who, exp_ack_c, resp_at, wait_m, lat, r;
    bit          out_v, exp_err, p_arb_ok, p_vr, p_ar, vack_prev, aack_p2;
    bit          e_rd, g_aud, a_now, arb_ok, allow_new;
    logic [15:0] out_addr, exp_data, p_va, p_aa;
    int          m_vid, m_aud, m_force;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst, vr, va, ar, aa, mv, md | rd, addr, vack, vdat, aack, adat, err
        vt[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0010, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 16'h0030, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 16'h0030, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 16'h0030, 1'b1, 16'h0040, 1'b1, 16'hAAAA, 1'b0, 16'h0030, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vt[10] = '{1'b1, 1'b1, 16'h0030, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0030, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
        vt[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0030, 1'b0, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
        vt[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
        vt[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h5555, 1'b0, 16'h0040, 1'b0, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
        vt[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'hAAAA, 1'b1, 16'h5555, 1'b0};
        vt[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'hAAAA, 1'b0, 16'h5555, 1'b0};
        vt[16] = '{1'b1, 1'b1, 16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'hAAAA, 1'b0, 16'h5555, 1'b0};
        vt[17] = '{1'b1, 1'b1, 16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0050, 1'b0, 16'hAAAA, 1'b0, 16'h5555, 1'b0};
        vt[18] = '{1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0050, 1'b0, 16'hAAAA, 1'b0, 16'h5555, 1'b0};
        vt[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[22] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[23] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};

        reset = 1'b0;
        vid_req = 1'b0; aud_req = 1'b0; mem_valid = 1'b0;
        vid_addr = '0; aud_addr = '0; mem_rdata = '0;
        next_cycle();
        do_reset();

        // ---------------- vector table ----------------
        for (int i = 0; i < 24; i++) begin
            reset = vt[i].rst_n;
            vid_req = vt[i].vr; vid_addr = vt[i].va;
            aud_req = vt[i].ar; aud_addr = vt[i].aa;
            mem_valid = vt[i].mv; mem_rdata = vt[i].md;
            @(negedge pclk);
            chk($sformatf("vec%0d mem_rd", i), 32'(mem_rd), 32'(vt[i].e_rd));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
            chk($sformatf("vec%0d vid_ack", i), 32'(vid_ack), 32'(vt[i].e_vack));
            chk($sformatf("vec%0d vid_rdata", i), 32'(vid_rdata), 32'(vt[i].e_vdat));
            chk($sformatf("vec%0d aud_ack", i), 32'(aud_ack), 32'(vt[i].e_aack));
            chk($sformatf("vec%0d aud_rdata", i), 32'(aud_rdata), 32'(vt[i].e_adat));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].e_err));
            next_cycle();
        end

        // ---------------- forced audio grant ----------------
        do_reset();
        vid_req = 1'b1; vid_addr = 16'h0100;
        aud_req = 1'b1; aud_addr = 16'h0200;
        first_aud = -1; nvid = 0; rd_prev = 1'b0; aack_prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mem_valid = rd_prev;
            mem_rdata = 16'h1000 + 16'(c);
            if (aack_prev) aud_req = 1'b0;
            @(negedge pclk);
            rd_prev = mem_rd;
            if (mem_rd) begin
                if (mem_addr == 16'h0200 && first_aud < 0) first_aud = c;
                else if (first_aud < 0) nvid++;
            end
            aack_prev = aud_ack;
            next_cycle();
        end
        chk("force_cycle", 32'(first_aud), 32'd17);
        chk("force_vid_before", 32'(nvid), 32'd4);
`ifdef ARB_STATS_EN
        chk("force_stat_force", 32'(stat_force), 32'd1);
        chk("force_stat_aud", 32'(stat_aud), 32'd1);
        chk("force_stat_vid", 32'(stat_vid), 32'd9);
`else
        chk("force_stat_force", 32'(stat_force), 32'd0);
        chk("force_stat_aud", 32'(stat_aud), 32'd0);
        chk("force_stat_vid", 32'(stat_vid), 32'd0);
`endif

        // ---------------- mem_valid on the timeout cycle ----------------
        do_reset();
        vid_req = 1'b1; vid_addr = 16'h0400;
        rd_c = -1; ack_c = -1; seen_err = 0; got_dat = '0; got_err = 1'b0;
        for (int c = 0; c < 100; c++) begin
            mem_valid = (rd_c >= 0) && (c == rd_c + TMO - 1);
            mem_rdata = 16'hCAFE;
            @(negedge pclk);
            if (mem_rd && rd_c < 0) rd_c = c;
            if (err) seen_err++;
            if (vid_ack && ack_c < 0) begin
                ack_c = c; got_dat = vid_rdata; got_err = err;
            end
            next_cycle();
            if (ack_c >= 0) vid_req = 1'b0;
        end
        mem_valid = 1'b0;
        chk("late_data rd_cycle", 32'(rd_c), 32'd1);
        chk("late_data ack_delay", 32'(ack_c - rd_c), 32'(TMO));
        chk("late_data rdata", 32'(got_dat), 32'h0000_CAFE);
        chk("late_data err", 32'(got_err), 32'd0);
        chk("late_data err_count", 32'(seen_err), 32'd0);

        // ---------------- timeout without reply ----------------
        repeat (2) next_cycle();
        vid_req = 1'b1; vid_addr = 16'h0300;
        rd_c = -1; ack_c = -1; err_c = -1; got_dat = 16'hFFFF; got_err = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge pclk);
            if (mem_rd && rd_c < 0) rd_c = c;
            if (err && err_c < 0) err_c = c;
            if (vid_ack && ack_c < 0) begin
                ack_c = c; got_dat = vid_rdata; got_err = err;
            end
            next_cycle();
            if (ack_c >= 0) vid_req = 1'b0;
        end
        chk("timeout rd_cycle", 32'(rd_c), 32'd1);
        chk("timeout ack_delay", 32'(ack_c - rd_c), 32'(TMO));
        chk("timeout rdata", 32'(got_dat), 32'd0);
        chk("timeout err", 32'(got_err), 32'd1);
        chk("timeout err_cycle", 32'(err_c), 32'(ack_c));

        // ---------------- randomized run vs reference ----------------
        do_reset();
        out_v = 0; p_arb_ok = 1; p_vr = 0; p_ar = 0; p_va = '0; p_aa = '0;
        wait_m = 0; vack_prev = 0; aack_p2 = 0; resp_at = -1;
        m_vid = 0; m_aud = 0; m_force = 0; out_who = 0; exp_ack_c = 0;
        exp_err = 0; exp_data = '0; out_addr = '0;
        for (cyc = 0; cyc < NRND; cyc++) begin
            allow_new = (cyc < NRND - 200);
            // requesters: hold until ack, then drop or re-request
            if (vid_req) begin
                if (vack_prev) begin
                    if (!allow_new || $urandom_range(1, 0) == 0) vid_req = 1'b0;
                    else vid_addr = 16'($urandom);
                end
            end else if (allow_new && $urandom_range(3, 0) != 0) begin
                vid_req = 1'b1; vid_addr = 16'($urandom);
            end
            if (aud_req) begin
                if (aack_p2) begin
                    if (!allow_new || $urandom_range(1, 0) == 0) aud_req = 1'b0;
                    else aud_addr = 16'($urandom);
                end
            end else if (allow_new && $urandom_range(3, 0) == 0) begin
                aud_req = 1'b1; aud_addr = 16'($urandom);
            end
            // memory: reply at the chosen cycle; stray strobes while idle
            mem_valid = 1'b0;
            mem_rdata = 16'($urandom);
            if (out_v && resp_at == cyc) begin
                mem_valid = 1'b1; mem_rdata = mem_f(out_addr);
            end else if (!out_v && !(p_arb_ok && (p_vr || p_ar)) && $urandom_range(7, 0) == 0) begin
                mem_valid = 1'b1;
            end

            @(negedge pclk);
            e_rd = p_arb_ok && (p_vr || p_ar);
            chk("rnd mem_rd", 32'(mem_rd), 32'(e_rd));
            g_aud = 0;
            if (e_rd) begin
                if (p_ar && wait_m >= MAXW) begin
                    g_aud = 1; m_force++;
                end else if (p_vr) begin
                    g_aud = 0;
                end else begin
                    g_aud = 1;
                end
                if (g_aud) begin
                    out_who = 1; out_addr = p_aa; m_aud++;
                end else begin
                    out_who = 0; out_addr = p_va; m_vid++;
                end
                chk("rnd mem_addr", 32'(mem_addr), 32'(out_addr));
                r = int'($urandom_range(31, 0));
                if (r == 0) lat = 0;
                else if (r == 1) lat = TMO - 1;
                else lat = int'($urandom_range(4, 1));
                out_v = 1;
                if (lat == 0) begin
                    resp_at = -1; exp_ack_c = cyc + TMO; exp_err = 1; exp_data = '0;
                end else begin
                    resp_at = cyc + lat; exp_ack_c = cyc + lat + 1; exp_err = 0;
                    exp_data = mem_f(out_addr);
                end
            end
            if (!p_ar || g_aud) wait_m = 0;
            else if (wait_m < MAXW) wait_m = wait_m + 1;

            a_now = out_v && (cyc == exp_ack_c);
            chk("rnd vid_ack", 32'(vid_ack), 32'(a_now && out_who == 0));
            chk("rnd aud_ack", 32'(aud_ack), 32'(a_now && out_who == 1));
            chk("rnd err", 32'(err), 32'(a_now && exp_err));
            if (a_now) begin
                if (out_who == 0) chk("rnd vid_rdata", 32'(vid_rdata), 32'(exp_data));
                else chk("rnd aud_rdata", 32'(aud_rdata), 32'(exp_data));
            end
            arb_ok = !out_v;
            if (a_now) out_v = 0;
            p_arb_ok = arb_ok;
            p_vr = vid_req; p_ar = aud_req; p_va = vid_addr; p_aa = aud_addr;
            vack_prev = a_now && out_who == 0;
            aack_p2 = a_now && out_who == 1;
            next_cycle();
        end
        chk("rnd drained", 32'(out_v), 32'd0);
`ifdef ARB_STATS_EN
        chk("rnd stat_vid", 32'(stat_vid), 32'(m_vid));
        chk("rnd stat_aud", 32'(stat_aud), 32'(m_aud));
        chk("rnd stat_force", 32'(stat_force), 32'(m_force));
`else
        chk("rnd stat_vid", 32'(stat_vid), 32'd0);
        chk("rnd stat_aud", 32'(stat_aud), 32'd0);
        chk("rnd stat_force", 32'(stat_force), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
